// File: rtl/modmul_multiplier.sv
// Sequential radix-4 shift-add multiplier feeding the modulus reducer.
// Each MULT cycle consumes one 2-bit digit of a. The result is handed over only while the reducer is idle.
//
// state | meaning
// IDLE  | waiting for ready_in; product_out holds the last result
// MULT  | accumulating one radix-4 partial product per cycle
// DONE  | result ready; waiting for the reducer to go idle
module modmul_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ready_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 downstream_busy_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 busy_out,
    output logic                 valid_out
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = $clog2(DIGITS);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a_sr;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_valid;

    logic                 w_capture;
    logic                 w_step;
    logic                 w_deliver;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_digit_ext;
    logic [2*WIDTH-1:0]   w_pp;
    logic [CW:0]          w_shamt;
    logic [2*WIDTH-1:0]   w_pp_shifted;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (ready_in)              w_state_nxt = S_MULT;
            S_MULT: if (r_cnt == LAST_DIGIT)   w_state_nxt = S_DONE;
            S_DONE: if (!downstream_busy_in)   w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_deliver = 1'b0;
        busy_out  = 1'b0;
        case (r_state)
            S_IDLE: w_capture = ready_in;
            S_MULT: begin
                w_step   = 1'b1;
                busy_out = 1'b1;
            end
            S_DONE: begin
                w_deliver = !downstream_busy_in;
                busy_out  = 1'b1;
            end
            default: ;
        endcase
    end

    // Partial product is built at full product width so the shift never truncates.
    assign w_b_ext      = {{WIDTH{1'b0}}, r_b};
    assign w_digit_ext  = {{(2*WIDTH-2){1'b0}}, r_a_sr[1:0]};
    assign w_pp         = w_b_ext * w_digit_ext;
    assign w_shamt      = {r_cnt, 1'b0};
    assign w_pp_shifted = w_pp << w_shamt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_a_sr    <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_deliver;
            if (w_deliver) begin
                r_product <= r_acc;
            end
            if (w_capture) begin
                r_a_sr <= a_in;
                r_b    <= b_in;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_acc  <= r_acc + w_pp_shifted;
                r_a_sr <= r_a_sr >> 2;
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    assign product_out = r_product;
    assign valid_out   = r_valid;

endmodule

// File: tb/tb_modmul_multiplier.sv
// Bench for modmul_multiplier: directed and random multiplications checked against a*b,
// with latency, stall, ignored-start, back-to-back and asynchronous-reset behaviour.
module tb_modmul_multiplier;

    localparam int W      = 16;
    localparam int DIGITS = W / 2;
    localparam int BASE_LAT = DIGITS + 1;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              ready_in = 1'b0;
    logic [W-1:0]      a_in = '0;
    logic [W-1:0]      b_in = '0;
    logic              downstream_busy_in = 1'b0;
    logic [2*W-1:0]    product_out;
    logic              busy_out;
    logic              valid_out;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] prev_product = '0;

    modmul_multiplier #(.WIDTH(W)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .ready_in           (ready_in),
        .a_in               (a_in),
        .b_in               (b_in),
        .downstream_busy_in (downstream_busy_in),
        .product_out        (product_out),
        .busy_out           (busy_out),
        .valid_out          (valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one multiplication at the current negedge and returns at the negedge where
    // valid_out is seen high. stall = edges the reducer stays busy once the result is ready;
    // poke = cycle index after capture at which a spurious ready_in (a=7,b=9) is pulsed.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, input int poke);
        logic [2*W-1:0] exp;
        int  k;
        bit  seen;
        bit  hold_ok;
        exp = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        a_in = a;
        b_in = b;
        ready_in = 1'b1;
        downstream_busy_in = 1'b1;
        @(negedge clk_in);
        k = 0;
        seen = 0;
        hold_ok = 1;
        ready_in = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        check({tag, "_busy_capture"}, {63'd0, busy_out}, 64'd1);
        check({tag, "_valid_capture"}, {63'd0, valid_out}, 64'd0);
        while (!seen && k < 60) begin
            downstream_busy_in = (k + 1 <= DIGITS + stall);
            ready_in = (poke > 0 && k + 1 == poke);
            if (ready_in) begin
                a_in = 16'd7;
                b_in = 16'd9;
            end
            @(negedge clk_in);
            k++;
            ready_in = 1'b0;
            if (valid_out === 1'b1) begin
                seen = 1;
            end else if (busy_out !== 1'b1 || product_out !== prev_product) begin
                hold_ok = 0;
            end
        end
        downstream_busy_in = 1'b0;
        check({tag, "_valid_seen"}, {63'd0, seen}, 64'd1);
        check({tag, "_latency"}, 64'(k), 64'(BASE_LAT + stall));
        check({tag, "_hold_while_busy"}, {63'd0, hold_ok}, 64'd1);
        check({tag, "_product"}, 64'(product_out), 64'(exp));
        check({tag, "_busy_at_valid"}, {63'd0, busy_out}, 64'd0);
        prev_product = exp;
    endtask

    // Idles for n cycles, confirming no further valid_out and a stable product_out.
    task automatic idle_check(input string tag, input int n);
        bit ok;
        ok = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (valid_out !== 1'b0 || busy_out !== 1'b0 || product_out !== prev_product) ok = 0;
        end
        check({tag, "_idle_quiet"}, {63'd0, ok}, 64'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit quiet;

        // Reset state
        #2;
        check("rst_product", 64'(product_out), 64'd0);
        check("rst_busy", {63'd0, busy_out}, 64'd0);
        check("rst_valid", {63'd0, valid_out}, 64'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Basic and boundary operands
        do_op("basic", 16'd3, 16'd5, 0, 0);
        idle_check("basic", 2);
        do_op("max", 16'hFFFF, 16'hFFFF, 0, 0);
        idle_check("max", 1);
        do_op("msb", 16'h8000, 16'h0002, 0, 0);
        idle_check("msb", 1);
        do_op("zero", 16'h0000, 16'hABCD, 0, 0);
        idle_check("zero", 1);
        do_op("one", 16'h0001, 16'hABCD, 0, 0);
        idle_check("one", 1);

        // Backpressure: reducer busy for 5 cycles after the result is ready
        do_op("stall5", 16'h1357, 16'h2468, 5, 0);
        idle_check("stall5", 1);

        // Ignored start in the 3rd MULT cycle, then back-to-back request in the valid cycle
        do_op("ignored", 16'd2, 16'd4, 0, 3);
        do_op("b2b", 16'h00FF, 16'h0101, 0, 0);
        idle_check("b2b", 3);

        // Random operands with random stalls
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op("rand", ra, rb, int'($urandom_range(0, 3)), 0);
        end
        idle_check("rand", 1);

        // Asynchronous reset in the middle of MULT
        a_in = 16'hBEEF;
        b_in = 16'h1234;
        ready_in = 1'b1;
        @(negedge clk_in);
        ready_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check("midrst_product", 64'(product_out), 64'd0);
        check("midrst_busy", {63'd0, busy_out}, 64'd0);
        check("midrst_valid", {63'd0, valid_out}, 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        prev_product = '0;
        quiet = 1;
        for (int i = 0; i < 2 * BASE_LAT; i++) begin
            @(negedge clk_in);
            if (valid_out !== 1'b0 || busy_out !== 1'b0) quiet = 0;
        end
        check("midrst_no_valid", {63'd0, quiet}, 64'd1);
        do_op("after_rst", 16'h1234, 16'h0010, 0, 0);
        idle_check("after_rst", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modmul_multiplier.md
Name: modmul_multiplier

Overview:
- Sequential radix-4 shift-add multiplier that sits directly upstream of the modulus reduction stage.
- Accepts two WIDTH-bit operands and produces the full 2*WIDTH-bit product for reduction.
- product_out wires to the reducer's value_in. valid_out wires to the reducer's ready_in. The reducer's busy_out returns as downstream_busy_in.
- The valid pulse is issued only when the reducer is idle, so no result is dropped.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4. Product width is 2*WIDTH.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- ready_in  input  1  start request; sampled only in IDLE.
- a_in  input  WIDTH  multiplier operand, unsigned.
- b_in  input  WIDTH  multiplicand operand, unsigned.
- downstream_busy_in  input  1  reducer busy; while high, result delivery is stalled.
- product_out  output  2*WIDTH  registered product a*b.
- busy_out  output  1  high from operand capture until the cycle valid_out asserts.
- valid_out  output  1  single-cycle pulse: product_out holds a new result.

Behaviour:
- Reset (rst_in low, asynchronous): state=IDLE; product_out=0; busy_out=0; valid_out=0; accumulator, operand and counter registers=0. Takes effect immediately, including mid-operation. The in-flight result is discarded and no valid_out is produced for it.
- States: IDLE, MULT, DONE.
- IDLE:
  - On an edge with ready_in=1: capture a_in into the shift register and b_in into the multiplicand register; clear accumulator; set digit counter=0; set busy_out<=1; go to MULT.
  - ready_in=0: remain in IDLE.
- MULT (exactly WIDTH/2 edges):
  - Each edge: acc <= acc + ((a_sr[1:0] * b) << (2*count)); a_sr >>= 2; count++.
  - Partial product is formed at 2*WIDTH bits. No overflow is possible since a*b < 2^(2*WIDTH).
  - On the edge where count == WIDTH/2-1, go to DONE.
- DONE, on each edge:
  - If downstream_busy_in=0: product_out <= acc; valid_out <= 1; busy_out <= 0; go to IDLE.
  - If downstream_busy_in=1: stay in DONE with busy_out high and valid_out low. Stall is unbounded.
- valid_out is registered and high for exactly one cycle, then returns to 0 on the next edge.
- product_out changes only on the DONE->IDLE edge (or reset). It holds its value until the next completed multiplication.
- Latency: if ready_in is sampled at edge E0 and there is no stall, valid_out is high after edge E0+WIDTH/2+1. For WIDTH=16 that is 9 cycles; each stalled cycle adds one.
- ready_in while busy (MULT or DONE) is ignored; there is no queueing.
- ready_in in the same cycle that valid_out is high: the state is IDLE, so it is accepted. Back-to-back throughput is one result per WIDTH/2+2 cycles.
- Operands are sampled only at capture. Changes to a_in/b_in afterwards have no effect on the in-flight result.
- A zero operand still takes the full WIDTH/2 MULT cycles; there is no early termination, so latency is data-independent.
- downstream_busy_in is ignored outside DONE.

Test Plan:
- Basic: WIDTH=16, a=3, b=5, ready_in one cycle, downstream idle -> valid_out one-cycle pulse 9 cycles after capture; product_out=0x0000000F; busy_out high for exactly 9 cycles.
- Max operands: a=b=0xFFFF -> product_out=0xFFFE0001. Also a=0x8000, b=0x0002 -> 0x00010000.
- Zero/identity: a=0, b=0xABCD -> 0x00000000 at the same 9-cycle latency. a=1, b=0xABCD -> 0x0000ABCD.
- Backpressure: hold downstream_busy_in high for 5 cycles after MULT completes -> no valid_out while high, busy_out stays 1. valid_out fires on the first edge after release with the correct product; the prior product_out is unchanged during the stall.
- Ignored start: pulse ready_in with a=7, b=9 in the 3rd MULT cycle of 2*4 -> only one valid_out, product_out=0x00000008. A back-to-back ready_in in the valid_out cycle is accepted and its result appears 9 cycles later.
- Reset mid-operation: assert rst_in low asynchronously during MULT -> outputs are 0 immediately and no valid_out follows. A fresh request after release computes correctly (e.g. 0x1234*0x0010 = 0x00012340).
